// File: rtl/xm23_dev_pkg.sv
// Shared XM23 device definitions: memory-mapped device offsets and timer CSR layout.
package xm23_dev_pkg;

   typedef enum logic [3:0] {
      DEV_KB_CSR   = 4'd0,
      DEV_KB_DATA  = 4'd1,
      DEV_SCR_CSR  = 4'd2,
      DEV_SCR_DATA = 4'd3,
      DEV_TMR_CSR  = 4'd4,
      DEV_TMR_DATA = 4'd5
   } dev_off_e;

   localparam int unsigned CSR_IE   = 0;
   localparam int unsigned CSR_DBA  = 2;
   localparam int unsigned CSR_OF   = 3;
   localparam int unsigned CSR_ENA  = 4;
   localparam int unsigned CSR_AUTO = 5;

   // Bits 1, 6 and 7 are unimplemented and always read as zero.
   function automatic logic [7:0] tmr_csr_pack(input logic ie, input logic dba,
                                               input logic of_flag, input logic ena,
                                               input logic auto_mode);
      logic [7:0] csr;
      csr           = '0;
      csr[CSR_IE]   = ie;
      csr[CSR_DBA]  = dba;
      csr[CSR_OF]   = of_flag;
      csr[CSR_ENA]  = ena;
      csr[CSR_AUTO] = auto_mode;
      return csr;
   endfunction

endpackage

// File: rtl/dev_timer_if.sv
// CPU-side strobe/data bus of the interval timer device.
interface dev_timer_if;
   logic       csr_wr;
   logic       csr_rd;
   logic       data_wr;
   logic [7:0] wdata;
   logic [7:0] csr_o;
   logic [7:0] data_o;
   logic [7:0] cnt_o;
   logic       irq;

   modport master (
      output csr_wr, csr_rd, data_wr, wdata,
      input  csr_o, data_o, cnt_o, irq
   );

   modport slave (
      input  csr_wr, csr_rd, data_wr, wdata,
      output csr_o, data_o, cnt_o, irq
   );
endinterface

// File: rtl/dev_timer_tick_gen.sv
// Prescaler: counts 0..PRESCALE-1 while enabled and flags the wrap cycle.
module tick_gen #(
   parameter int unsigned PRESCALE = 50000
) (
   input  logic Clock,
   input  logic Reset,
   input  logic clr,
   input  logic en,
   output logic tick
);

   localparam int unsigned W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [W-1:0] LAST = W'(PRESCALE - 1);

   logic [W-1:0] count_q, count_d;

   always_comb begin
      tick    = en && (count_q == LAST);
      count_d = count_q + 1'b1;
      if (clr || !en || tick) begin
         count_d = '0;
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/dev_timer.sv
// XM23 interval timer: 8-bit down-counter clocked by a prescaled tick, with
// expiry/overrun flags, optional auto-reload and a level interrupt.
module dev_timer
   import xm23_dev_pkg::*;
#(
   parameter int unsigned PRESCALE = 50000
) (
   input logic        Clock,
   input logic        Reset,
   dev_timer_if.slave bus
);

   logic       ie_q, ie_d;
   logic       dba_q, dba_d;
   logic       of_q, of_d;
   logic       ena_q, ena_d;
   logic       auto_q, auto_d;
   logic       irq_q, irq_d;
   logic [7:0] cnt_q, cnt_d;
   logic [7:0] reload_q, reload_d;

   logic tick;
   logic start;
   logic expiry;

   tick_gen #(.PRESCALE(PRESCALE)) u_tick_gen (
      .Clock (Clock),
      .Reset (Reset),
      .clr   (start),
      .en    (ena_q),
      .tick  (tick)
   );

   always_comb begin
      start  = bus.csr_wr && !ena_q && bus.wdata[CSR_ENA];
      expiry = tick && (cnt_q == 8'd1);

      ie_d     = ie_q;
      ena_d    = ena_q;
      auto_d   = auto_q;
      cnt_d    = cnt_q;
      reload_d = reload_q;

      if (bus.csr_wr) begin
         ie_d   = bus.wdata[CSR_IE];
         ena_d  = bus.wdata[CSR_ENA];
         auto_d = bus.wdata[CSR_AUTO];
      end else if (expiry && !auto_q) begin
         ena_d = 1'b0;
      end

      // A counter of 0 decrements to 255, so reload 0 yields a 256-tick period.
      if (start) begin
         cnt_d = reload_q;
      end else if (expiry) begin
         cnt_d = auto_q ? reload_q : '0;
      end else if (tick) begin
         cnt_d = cnt_q - 8'd1;
      end

      // Expiry beats a coincident read; overrun is judged against pre-read DBA.
      if (expiry) begin
         dba_d = 1'b1;
         of_d  = dba_q || (of_q && !bus.csr_rd);
      end else if (bus.csr_rd) begin
         dba_d = 1'b0;
         of_d  = 1'b0;
      end else begin
         dba_d = dba_q;
         of_d  = of_q;
      end

      if (bus.data_wr) begin
         reload_d = bus.wdata;
      end

      irq_d = ie_d && dba_d;
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         ie_q     <= 1'b0;
         dba_q    <= 1'b0;
         of_q     <= 1'b0;
         ena_q    <= 1'b0;
         auto_q   <= 1'b0;
         irq_q    <= 1'b0;
         cnt_q    <= '0;
         reload_q <= '0;
      end else begin
         ie_q     <= ie_d;
         dba_q    <= dba_d;
         of_q     <= of_d;
         ena_q    <= ena_d;
         auto_q   <= auto_d;
         irq_q    <= irq_d;
         cnt_q    <= cnt_d;
         reload_q <= reload_d;
      end
   end

   assign bus.csr_o  = tmr_csr_pack(ie_q, dba_q, of_q, ena_q, auto_q);
   assign bus.data_o = reload_q;
   assign bus.cnt_o  = cnt_q;
   assign bus.irq    = irq_q;

endmodule

// File: tb/tb_dev_timer.sv
// Self-checking bench for dev_timer: directed scenarios plus random traffic against
// a cycles-until-expiry reference model.
module tb_dev_timer;

   localparam int P = 4;

   logic Clock = 1'b0;
   logic Reset;

   dev_timer_if bus ();

   dev_timer #(.PRESCALE(P)) dut (
      .Clock (Clock),
      .Reset (Reset),
      .bus   (bus)
   );

   always #5 Clock = ~Clock;

   int checks = 0;
   int errors = 0;

   // Reference model: remaining cycles to next expiry, not a counter/prescaler pair.
   bit       m_running;
   int       m_rem;
   int       m_hold;
   int       m_reload;
   bit       m_ie;
   bit       m_auto;
   int       m_n;      // expiries since the last acknowledging read
   bit       m_of;

   function automatic int eff(input int r);
      return (r == 0) ? 256 : r;
   endfunction

   function automatic logic [7:0] exp_cnt();
      if (m_running) return 8'(((m_rem + P - 1) / P) % 256);
      return 8'(m_hold);
   endfunction

   function automatic logic [7:0] exp_csr();
      logic [7:0] c;
      c = 8'h00;
      c[0] = m_ie;
      c[2] = (m_n > 0);
      c[3] = m_of;
      c[4] = m_running;
      c[5] = m_auto;
      return c;
   endfunction

   task automatic model_update(input bit rst, input bit wr, input bit rd,
                               input bit dwr, input logic [7:0] wd);
      bit ex;
      if (rst) begin
         m_running = 0; m_rem = 0; m_hold = 0; m_reload = 0;
         m_ie = 0; m_auto = 0; m_n = 0; m_of = 0;
         return;
      end
      ex = 0;
      if (m_running) begin
         m_rem = m_rem - 1;
         if (m_rem == 0) begin
            ex = 1;
            if (m_auto) m_rem = eff(m_reload) * P;
            else begin
               m_running = 0;
               m_hold    = 0;
            end
         end
      end
      if (ex && rd) begin
         m_of = (m_n > 0);
         m_n  = 1;
      end else if (ex) begin
         m_of = m_of || (m_n > 0);
         m_n  = m_n + 1;
      end else if (rd) begin
         m_n  = 0;
         m_of = 0;
      end
      if (wr) begin
         m_ie   = wd[0];
         m_auto = wd[5];
         if (wd[4] && !m_running) begin
            m_running = 1;
            m_rem     = eff(m_reload) * P;
         end else if (!wd[4] && m_running) begin
            m_hold    = ((m_rem + P - 1) / P) % 256;
            m_running = 0;
         end
      end
      if (dwr) m_reload = int'(wd);
   endtask

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step(input bit rst, input bit wr, input bit rd,
                       input bit dwr, input logic [7:0] wd);
      Reset       = rst;
      bus.csr_wr  = wr;
      bus.csr_rd  = rd;
      bus.data_wr = dwr;
      bus.wdata   = wd;
      @(posedge Clock);
      model_update(rst, wr, rd, dwr, wd);
      #1;
      chk("model_csr",  bus.csr_o,  exp_csr());
      chk("model_data", bus.data_o, 8'(m_reload));
      chk("model_cnt",  bus.cnt_o,  exp_cnt());
      chk("model_irq",  {7'd0, bus.irq}, {7'd0, m_ie && (m_n > 0)});
      Reset       = 1'b0;
      bus.csr_wr  = 1'b0;
      bus.csr_rd  = 1'b0;
      bus.data_wr = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 8'h00);
   endtask

   initial begin
      bit          wr, rd, dwr, rst;
      logic [7:0]  wd;
      Reset = 1'b1;
      bus.csr_wr = 1'b0; bus.csr_rd = 1'b0; bus.data_wr = 1'b0; bus.wdata = 8'h00;

      // Reset state
      step(1, 0, 0, 0, 8'h00);
      chk("rst_csr", bus.csr_o, 8'h00);
      chk("rst_cnt", bus.cnt_o, 8'h00);

      // One-shot, reload 3: expiry 12 cycles after the enabling write
      step(0, 0, 0, 1, 8'h03);
      step(0, 1, 0, 0, 8'h10);
      idle(11);
      chk("oneshot_pre_csr", bus.csr_o, 8'h10);
      chk("oneshot_pre_cnt", bus.cnt_o, 8'h01);
      idle(1);
      chk("oneshot_csr", bus.csr_o, 8'h04);
      chk("oneshot_cnt", bus.cnt_o, 8'h00);
      chk("oneshot_irq", {7'd0, bus.irq}, 8'h00);

      // Auto-reload 2 with interrupts, read acknowledges
      step(1, 0, 0, 0, 8'h00);
      step(0, 0, 0, 1, 8'h02);
      step(0, 1, 0, 0, 8'h31);
      idle(7);
      chk("auto_irq7", {7'd0, bus.irq}, 8'h00);
      idle(1);
      chk("auto_irq8", {7'd0, bus.irq}, 8'h01);
      idle(1);
      step(0, 0, 1, 0, 8'h00);
      chk("auto_irq10", {7'd0, bus.irq}, 8'h00);
      idle(5);
      chk("auto_irq15", {7'd0, bus.irq}, 8'h00);
      idle(1);
      chk("auto_irq16", {7'd0, bus.irq}, 8'h01);
      chk("auto_csr16", bus.csr_o, 8'h35);

      // Overrun: reload 1, two expiries unread
      step(1, 0, 0, 0, 8'h00);
      step(0, 0, 0, 1, 8'h01);
      step(0, 1, 0, 0, 8'h31);
      idle(4);
      chk("of_first", bus.csr_o, 8'h35);
      idle(4);
      chk("of_second", bus.csr_o, 8'h3D);
      step(0, 0, 1, 0, 8'h00);
      chk("of_read", bus.csr_o, 8'h31);

      // Read on the exact expiry cycle
      step(1, 0, 0, 0, 8'h00);
      step(0, 0, 0, 1, 8'h02);
      step(0, 1, 0, 0, 8'h31);
      idle(7);
      step(0, 0, 1, 0, 8'h00);
      chk("rdexp_csr", bus.csr_o, 8'h35);
      chk("rdexp_irq", {7'd0, bus.irq}, 8'h01);

      // Disabling write on the expiry cycle still sets DBA
      step(1, 0, 0, 0, 8'h00);
      step(0, 0, 0, 1, 8'h02);
      step(0, 1, 0, 0, 8'h31);
      idle(7);
      step(0, 1, 0, 0, 8'h01);
      chk("wrexp_csr", bus.csr_o, 8'h05);
      idle(10);
      chk("wrexp_hold_csr", bus.csr_o, 8'h05);
      chk("wrexp_hold_cnt", bus.cnt_o, 8'h02);

      // ENA 1->1 rewrite must not disturb timing
      step(1, 0, 0, 0, 8'h00);
      step(0, 0, 0, 1, 8'h03);
      step(0, 1, 0, 0, 8'h10);
      idle(5);
      step(0, 1, 0, 0, 8'h11);
      idle(5);
      chk("rewr_pre", bus.csr_o, 8'h11);
      idle(1);
      chk("rewr_exp", bus.csr_o, 8'h05);

      // Reload 0 means 256 ticks; reset mid-count abandons the run
      step(1, 0, 0, 0, 8'h00);
      step(0, 0, 0, 1, 8'h00);
      step(0, 1, 0, 0, 8'h10);
      idle(1023);
      chk("r0_pre", bus.csr_o, 8'h10);
      idle(1);
      chk("r0_exp_csr", bus.csr_o, 8'h04);
      chk("r0_exp_cnt", bus.cnt_o, 8'h00);
      step(0, 0, 1, 0, 8'h00);
      step(0, 1, 0, 0, 8'h10);
      idle(499);
      step(1, 0, 0, 0, 8'h00);
      chk("midrst_csr",  bus.csr_o,  8'h00);
      chk("midrst_data", bus.data_o, 8'h00);
      chk("midrst_cnt",  bus.cnt_o,  8'h00);
      chk("midrst_irq",  {7'd0, bus.irq}, 8'h00);
      idle(1100);
      chk("midrst_after", bus.csr_o, 8'h00);

      // Random traffic; writes avoid the expiry cycle itself
      for (int i = 0; i < 4000; i++) begin
         rst = ($urandom_range(0, 699) == 0);
         wr  = ($urandom_range(0, 15) == 0) && !(m_running && m_rem == 1);
         rd  = ($urandom_range(0, 7) == 0);
         dwr = ($urandom_range(0, 15) == 0);
         wd  = 8'($urandom);
         if (dwr && !wr && $urandom_range(0, 3) != 0) wd = 8'($urandom_range(0, 6));
         step(rst, wr, rd, dwr, wd);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/dev_timer.md
DEV_TIMER -- requirements
Module: dev_timer

Interface
REQ-001 SHALL have parameter PRESCALE, default 50000, meaning Clock cycles per timer tick (1 ms at 50 MHz); legal range 1..65535.
REQ-002 SHALL have port Clock  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port Reset  in  1  synchronous, active-high reset, sampled on rising edge of Clock.
REQ-004 SHALL have port csr_wr  in  1  one-cycle strobe: write wdata to tmr_csr (device offset 4).
REQ-005 SHALL have port csr_rd  in  1  one-cycle strobe: CPU has read tmr_csr (side effects below).
REQ-006 SHALL have port data_wr  in  1  one-cycle strobe: write wdata to tmr_data (device offset 5).
REQ-007 SHALL have port wdata  in  8  write data from MDR low byte.
REQ-008 SHALL have port csr_o  out  8  registered tmr_csr image copied into device memory.
REQ-009 SHALL have port data_o  out  8  registered reload value (tmr_data image).
REQ-010 SHALL have port cnt_o  out  8  current down-counter value (debug / HEX display).
REQ-011 SHALL have port irq  out  1  level interrupt request to PIC = IE AND DBA.

Function
REQ-012 CSR bits SHALL be: 0 IE, 2 DBA (expired), 3 OF (overrun), 4 ENA (run), 5 AUTO (reload); bits 1,6,7 read 0.
REQ-013 Prescaler SHALL count 0..PRESCALE-1 while ENA=1 and emit a one-cycle tick on wrap; held at 0 while ENA=0.
REQ-014 On each tick, counter SHALL decrement by 1; the tick on which counter=1 is expiry, counter becomes 0.
REQ-015 On expiry SHALL: set DBA; set OF if DBA was already 1; if AUTO=1 load counter from reload in the same cycle, else clear ENA and hold counter at 0.
REQ-016 Reload value 0 SHALL mean 256 ticks (counter loads 0, expires on the 256th tick via 8-bit wrap).
REQ-017 csr_wr SHALL update IE, ENA, AUTO from wdata; DBA and OF SHALL ignore written values.
REQ-018 ENA 0->1 via csr_wr SHALL load counter from reload and clear prescaler; first expiry exactly reload*PRESCALE cycles after the write edge.
REQ-019 csr_wr with ENA 1->1 SHALL not disturb counter or prescaler.
REQ-020 csr_rd SHALL clear DBA and OF on the following edge.
REQ-021 Expiry coincident with csr_rd SHALL win: DBA=1 afterwards, OF computed from pre-read DBA, then cleared by the read only if not re-set.
REQ-022 Expiry coincident with csr_wr clearing ENA SHALL still set DBA; counter then stops.
REQ-023 data_wr SHALL update reload only; a running counter SHALL pick up the new value at its next reload.
REQ-024 All outputs SHALL be registered; effects of a strobe visible on outputs one cycle after the strobe edge.

Reset
REQ-025 Reset SHALL force csr_o=8'h00, data_o=8'h00, cnt_o=8'h00, irq=0, prescaler=0.
REQ-026 Reset SHALL override any coincident strobe or expiry; reset mid-count SHALL abandon the count with no DBA set.

Structure
REQ-027 CSR bit positions and device offsets (kb_csr=0, kb_data=1, scr_csr=2, scr_data=3, tmr_csr=4, tmr_data=5) SHALL live in shared package xm23_dev_pkg, reused by kb_scr_drv integration.
REQ-028 Prescaler SHALL be a separate sub-module tick_gen (inputs Clock, Reset, clr, en; output tick; parameter PRESCALE).
REQ-029 Block SHALL contain no knowledge of MAR/MDR decoding; the CPU top generates strobes from mar[3:0].

Verification (PRESCALE=4)
REQ-030 Reset, data_wr 8'h03, csr_wr 8'h10 -> expiry 12 cycles later: csr_o=8'h04, cnt_o=0, ENA cleared, irq=0.
REQ-031 data_wr 8'h02, csr_wr 8'h31 (IE,ENA,AUTO) -> irq rises at cycle 8; csr_rd at cycle 10 -> irq=0; irq rises again at cycle 16.
REQ-032 AUTO run reload 1 with no csr_rd -> second expiry at cycle 8 sets OF: csr_o=8'h3D; one csr_rd -> csr_o=8'h31.
REQ-033 csr_rd asserted on exact expiry cycle -> DBA=1 afterwards, OF=0, irq stays high.
REQ-034 data_wr 8'h00, csr_wr 8'h10 -> expiry at cycle 1024; Reset asserted at cycle 500 of a second run -> all outputs 0, no expiry.
